// File: rtl/switch_mcu_pkg.sv
// Shared constants and types for the switch MCU core.
package switch_mcu_pkg;

  localparam int unsigned MCU_DATA_W     = 32;
  localparam int unsigned MCU_REG_ADDR_W = 5;
  localparam int unsigned MCU_NUM_REGS   = 32;

  typedef logic [MCU_DATA_W-1:0]     mcu_word_t;
  typedef logic [MCU_REG_ADDR_W-1:0] mcu_reg_idx_t;

endpackage

// File: rtl/switch_mcu_regfile.sv
// Single-port general register file: shared address, synchronous write,
// combinational read, synchronous clear of every entry.
module switch_mcu_regfile
  import switch_mcu_pkg::*;
#(
  parameter int unsigned DATA_W = MCU_DATA_W,
  parameter int unsigned ADDR_W = MCU_REG_ADDR_W,
  parameter int unsigned DEPTH  = MCU_NUM_REGS   // must equal 2**ADDR_W
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic [DATA_W-1:0] out_rdata,
  input  logic              in_wr
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  wr_en;

  always_comb begin
    wr_en = '0;
    if (in_wr) wr_en[in_addr] = 1'b1;
  end

  // One flop bank per entry so the reset clear stays out of RAM inference.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge in_clk) begin
      if (in_rst)        regs[g] <= '0;
      else if (wr_en[g]) regs[g] <= in_wdata;
    end
  end

  assign out_rdata = regs[in_addr];

endmodule

// File: tb/tb_switch_mcu_regfile.sv
// Scoreboard bench for switch_mcu_regfile: a reference register model
// supplies expected read values, queued at drive time and checked on sample.
module tb_switch_mcu_regfile;
  import switch_mcu_pkg::*;

  logic         in_clk = 1'b0;
  logic         in_rst;
  logic         in_wr;
  mcu_reg_idx_t in_addr;
  mcu_word_t    in_wdata;
  mcu_word_t    out_rdata;

  always #5 in_clk = ~in_clk;

  switch_mcu_regfile #(
    .DATA_W(MCU_DATA_W),
    .ADDR_W(MCU_REG_ADDR_W),
    .DEPTH (MCU_NUM_REGS)
  ) dut (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_addr  (in_addr),
    .in_wdata (in_wdata),
    .out_rdata(out_rdata),
    .in_wr    (in_wr)
  );

  typedef struct {
    string     tag;
    mcu_word_t exp;
  } exp_t;

  exp_t      sb[$];
  mcu_word_t model [MCU_NUM_REGS];
  int        checks = 0;
  int        errors = 0;

  task automatic check_eq(input string tag, input mcu_word_t obs, input mcu_word_t exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive one clock edge and advance the reference model alongside it.
  task automatic cycle(input bit rst, input bit wr, input mcu_reg_idx_t a, input mcu_word_t d);
    in_rst   = rst;
    in_wr    = wr;
    in_addr  = a;
    in_wdata = d;
    @(posedge in_clk);
    if (rst) begin
      for (int unsigned i = 0; i < MCU_NUM_REGS; i++) model[i] = '0;
    end else if (wr) begin
      model[a] = d;
    end
    #1;
  endtask

  task automatic read_at(input mcu_reg_idx_t a, input string tag);
    exp_t e;
    in_addr = a;
    sb.push_back('{tag, model[a]});
    #1;
    e = sb.pop_front();
    check_eq(e.tag, out_rdata, e.exp);
  endtask

  initial begin
    in_rst = 1'b0; in_wr = 1'b0; in_addr = '0; in_wdata = '0;
    for (int unsigned i = 0; i < MCU_NUM_REGS; i++) model[i] = 'x;
    @(negedge in_clk);

    // 1. reset clear
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0);
    in_rst = 1'b0;
    for (int unsigned i = 0; i < MCU_NUM_REGS; i++)
      read_at(mcu_reg_idx_t'(i), $sformatf("reset_clear[%0d]", i));

    // 2. basic write/read
    cycle(1'b0, 1'b1, 5'd1, 32'h0000_1234);
    cycle(1'b0, 1'b1, 5'd2, 32'h0000_2345);
    cycle(1'b0, 1'b0, 5'd1, 32'h0);
    read_at(5'd2, "basic_r2");
    read_at(5'd1, "basic_r1");
    check_eq("basic_r1_const", out_rdata, 32'h0000_1234);

    // 3. write-enable gating
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 5'd5, 32'hDEAD_BEEF);
    read_at(5'd5, "wr_gate_r5");
    check_eq("wr_gate_r5_const", out_rdata, 32'h0);

    // 4. read-during-write, no bypass
    cycle(1'b0, 1'b1, 5'd3, 32'h0000_AAAA);
    in_wr = 1'b1; in_wdata = 32'h0000_5555;
    read_at(5'd3, "rdw_before");
    @(posedge in_clk);
    model[3] = 32'h0000_5555;
    #1;
    in_wr = 1'b0;
    read_at(5'd3, "rdw_after");

    // 5. reset priority over write, clears earlier data
    cycle(1'b1, 1'b1, 5'd7, 32'h0000_FFFF);
    in_wr = 1'b0;
    read_at(5'd7, "rst_prio_r7");
    read_at(5'd1, "rst_prio_r1");
    check_eq("rst_prio_r1_const", out_rdata, 32'h0);
    in_rst = 1'b0;

    // 6. full sweep, back-to-back writes
    for (int unsigned i = 0; i < MCU_NUM_REGS; i++)
      cycle(1'b0, 1'b1, mcu_reg_idx_t'(i), 32'hA5A5_0000 | i);
    in_wr = 1'b0;
    for (int unsigned i = 0; i < MCU_NUM_REGS; i++)
      read_at(mcu_reg_idx_t'(i), $sformatf("sweep[%0d]", i));
    read_at(5'd0, "sweep_r0_again");
    check_eq("sweep_r0_const", out_rdata, 32'hA5A5_0000);
    read_at(5'd31, "sweep_r31_again");
    check_eq("sweep_r31_const", out_rdata, 32'hA5A5_001F);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_mcu_regfile.md
Name:
switch_mcu_regfile

Overview:
- Single-port 32 x 32-bit general register file for the switch MCU core.
- Sits between the MCU datapath and its load/store/ALU operand logic.
- One shared address selects both the write target and the read source.
- Writes are synchronous; the read path is combinational.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, address width.
- DEPTH, 32, number of registers; must equal 2**ADDR_W.

Ports:
- in_clk  input  1  system clock; all state updates on the rising edge.
- in_rst  input  1  reset, synchronous, active-high. Clears all registers.
- in_addr  input  ADDR_W  register index for both read and write.
- in_wdata  input  DATA_W  write data.
- out_rdata  output  DATA_W  contents of register in_addr.
- in_wr  input  1  write enable, active-high.

Behaviour:
- Storage: DEPTH registers of DATA_W bits, indices 0..DEPTH-1.
- All registers are general purpose, including register 0. Register 0 is not hardwired to zero.
- Reset:
  - On a rising edge of in_clk with in_rst=1, every register becomes 0.
  - Reset has priority over in_wr; a write in a reset cycle is discarded.
  - While in_rst=1, out_rdata reads 0 for every address from the cycle after the first reset edge.
  - Before the first reset edge, register contents are undefined.
- Write:
  - On a rising edge with in_rst=0 and in_wr=1, reg[in_addr] <= in_wdata.
  - Exactly one register is updated per cycle.
  - With in_wr=0, no register changes; in_wdata is ignored.
- Read:
  - out_rdata = reg[in_addr], purely combinational, zero-cycle latency from in_addr.
  - No output register.
- Read-during-write, same cycle and same address:
  - Before the edge, out_rdata shows the old value.
  - After the edge, out_rdata shows the new value.
  - No write-through bypass.
- Address range: all 5-bit codes are valid; no out-of-range case exists at DEPTH=32.
- No handshake and no busy/ready signalling; the block accepts a write every cycle.
- Back-to-back writes to different addresses on consecutive cycles both take effect.
- Reset asserted mid-sequence clears everything, including registers written just before it.

Decomposition:
- Shared package switch_mcu_pkg holds:
  - constants MCU_DATA_W=32, MCU_REG_ADDR_W=5, MCU_NUM_REGS=32;
  - typedefs mcu_word_t (logic [31:0]) and mcu_reg_idx_t (logic [4:0]).
- Single flat module with no sub-modules.
- Storage is a register array with a per-entry write-enable decode, so reset of all entries is synthesizable; no RAM macro inference.

Test Plan:
1. Reset clear: hold in_rst=1 for 2 edges, then sweep in_addr 0..31 with in_wr=0 -> out_rdata=0x00000000 for every address.
2. Basic write/read:
   - Edge 1: in_rst=0, in_wr=1, addr=1, wdata=0x1234.
   - Edge 2: addr=2, wdata=0x2345.
   - Then in_wr=0, wdata=0.
   - Required: addr=2 reads 0x2345; addr=1 reads 0x1234; wdata=0 with in_wr=0 does not overwrite.
3. Write-enable gating: in_wr=0, addr=5, wdata=0xDEADBEEF for 3 edges -> addr=5 still reads 0.
4. Read-during-write: reg[3]=0xAAAA, then in_wr=1, addr=3, wdata=0x5555 -> out_rdata=0xAAAA before the edge, 0x5555 immediately after.
5. Reset priority: in_rst=1 and in_wr=1, addr=7, wdata=0xFFFF at the same edge -> reg[7]=0. Previously written reg[1]=0x1234 also reads 0 after this edge.
6. Full sweep:
   - Write reg[i]=0xA5A50000|i for i=0..31 on consecutive edges.
   - Read back all 32 -> each matches, including reg[0]=0xA5A50000 and reg[31]=0xA5A5001F.
